demux64_16_bank: RTL and testbench

//  Write-side partner of the 16:1 64-bit read mux. It holds 16 x 64-bit registers (q0..q15) that feed the mux inputs.
//  It accepts one write per cycle through a valid/ready handshake and decodes wr_sel into a one-hot enable.
//  It applies the per-byte mask and provides a 16-cycle sequential clear sweep. Sits in the CPU datapath as the register-bank write port.

---
 rtl/cpu_regbank_pkg.sv | 14 +
 rtl/dec4_16.sv | 16 +
 rtl/demux64_16_bank.sv | 141 ++++++++++++++
 tb/tb_demux64_16_bank.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_regbank_pkg.sv
// Shared types and sizes for the CPU register-bank write port.
package cpu_regbank_pkg;

  localparam int REG_WIDTH = 64;
  localparam int REG_DEPTH = 16;

  typedef logic [3:0] reg_sel_t;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } bank_state_t;

endpackage

// File: rtl/dec4_16.sv
// Combinational 4-to-16 one-hot decoder with enable.
module dec4_16 (
  input  logic        i_en,
  input  logic [3:0]  i_sel,
  output logic [15:0] o_onehot
);

  // Drive the selected line high only when enabled.
  always_comb begin
    o_onehot = '0;
    if (i_en) begin
      o_onehot[i_sel] = 1'b1;
    end
  end

endmodule

// File: rtl/demux64_16_bank.sv
// Register-bank write port: 16 x WIDTH registers with valid/ready byte-masked
// writes and a one-register-per-cycle clear sweep.
module demux64_16_bank
  import cpu_regbank_pkg::*;
#(
  parameter int WIDTH     = REG_WIDTH,
  parameter int DEPTH     = REG_DEPTH,
  parameter int ZERO_REG0 = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic [3:0]         wr_sel,
  input  logic [WIDTH-1:0]   wr_data,
  input  logic [WIDTH/8-1:0] wr_be,
  input  logic               clr_req,
  output logic               busy,
  output logic [WIDTH-1:0]   q0,
  output logic [WIDTH-1:0]   q1,
  output logic [WIDTH-1:0]   q2,
  output logic [WIDTH-1:0]   q3,
  output logic [WIDTH-1:0]   q4,
  output logic [WIDTH-1:0]   q5,
  output logic [WIDTH-1:0]   q6,
  output logic [WIDTH-1:0]   q7,
  output logic [WIDTH-1:0]   q8,
  output logic [WIDTH-1:0]   q9,
  output logic [WIDTH-1:0]   q10,
  output logic [WIDTH-1:0]   q11,
  output logic [WIDTH-1:0]   q12,
  output logic [WIDTH-1:0]   q13,
  output logic [WIDTH-1:0]   q14,
  output logic [WIDTH-1:0]   q15
);

  localparam reg_sel_t LAST = reg_sel_t'(DEPTH - 1);

  bank_state_t      r_state;
  bank_state_t      w_state_nxt;
  reg_sel_t         r_cnt;
  reg_sel_t         w_cnt_nxt;
  logic [WIDTH-1:0] r_q [DEPTH];

  logic             w_wr_fire;
  logic [15:0]      w_wr_en;
  logic [15:0]      w_clr_en;
  logic [WIDTH-1:0] w_mask;

  assign wr_ready  = (r_state == IDLE) && !reset;
  assign busy      = (r_state == CLEAR) && !reset;
  assign w_wr_fire = wr_valid && wr_ready;

  dec4_16 u_dec_wr (
    .i_en     (w_wr_fire),
    .i_sel    (wr_sel),
    .o_onehot (w_wr_en)
  );

  dec4_16 u_dec_clr (
    .i_en     (r_state == CLEAR),
    .i_sel    (r_cnt),
    .o_onehot (w_clr_en)
  );

  // Expand byte enables into a bit mask over the data word.
  always_comb begin
    w_mask = '0;
    for (int unsigned b = 0; b < WIDTH / 8; b++) begin
      w_mask[8*b +: 8] = {8{wr_be[b]}};
    end
  end

  // Next-state and sweep counter; counter wraps to 0 naturally on exit.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (clr_req) begin
          w_state_nxt = CLEAR;
        end
      end
      CLEAR: begin
        w_cnt_nxt = r_cnt + 4'd1;
        if (r_cnt == LAST) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register and sweep counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Per-register update: sweep clear, else byte-masked write; q0 optionally tied to 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned k = 0; k < DEPTH; k++) begin
        r_q[k] <= '0;
      end
    end else begin
      for (int unsigned k = 0; k < DEPTH; k++) begin
        if ((ZERO_REG0 != 0) && (k == 0)) begin
          r_q[k] <= '0;
        end else if (w_clr_en[k]) begin
          r_q[k] <= '0;
        end else if (w_wr_en[k]) begin
          r_q[k] <= (r_q[k] & ~w_mask) | (wr_data & w_mask);
        end
      end
    end
  end

  assign q0  = r_q[0];
  assign q1  = r_q[1];
  assign q2  = r_q[2];
  assign q3  = r_q[3];
  assign q4  = r_q[4];
  assign q5  = r_q[5];
  assign q6  = r_q[6];
  assign q7  = r_q[7];
  assign q8  = r_q[8];
  assign q9  = r_q[9];
  assign q10 = r_q[10];
  assign q11 = r_q[11];
  assign q12 = r_q[12];
  assign q13 = r_q[13];
  assign q14 = r_q[14];
  assign q15 = r_q[15];

endmodule

// File: tb/tb_demux64_16_bank.sv
// Scoreboard bench for demux64_16_bank: stimulus queues expectations tagged
// with the cycle they are due; a negedge monitor compares them.
module tb_demux64_16_bank;

  localparam int IDX_BUSY  = 16;
  localparam int IDX_READY = 17;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_valid;
  logic        wr_ready;
  logic [3:0]  wr_sel;
  logic [63:0] wr_data;
  logic [7:0]  wr_be;
  logic        clr_req;
  logic        busy;
  logic [63:0] tq [16];

  typedef struct {
    int          cyc;
    int          idx;
    logic [63:0] v;
  } exp_t;

  exp_t sb[$];
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;
  int   c0;

  demux64_16_bank #(.WIDTH(64), .DEPTH(16), .ZERO_REG0(1)) dut (
    .clk      (clk),
    .reset    (reset),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_sel   (wr_sel),
    .wr_data  (wr_data),
    .wr_be    (wr_be),
    .clr_req  (clr_req),
    .busy     (busy),
    .q0  (tq[0]),  .q1  (tq[1]),  .q2  (tq[2]),  .q3  (tq[3]),
    .q4  (tq[4]),  .q5  (tq[5]),  .q6  (tq[6]),  .q7  (tq[7]),
    .q8  (tq[8]),  .q9  (tq[9]),  .q10 (tq[10]), .q11 (tq[11]),
    .q12 (tq[12]), .q13 (tq[13]), .q14 (tq[14]), .q15 (tq[15])
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Queue an expectation due d cycles from the current one.
  task automatic expect_at(input int d, input int idx, input logic [63:0] v);
    exp_t e;
    e.cyc = cyc + d;
    e.idx = idx;
    e.v   = v;
    sb.push_back(e);
  endtask

  function automatic logic [63:0] actual(input int idx);
    if (idx == IDX_BUSY)  return {63'd0, busy};
    if (idx == IDX_READY) return {63'd0, wr_ready};
    return tq[idx];
  endfunction

  // Monitor: compare every expectation due in this cycle.
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        logic [63:0] a;
        a = actual(sb[i].idx);
        total++;
        if (a !== sb[i].v) begin
          bad++;
          if (sb[i].idx == IDX_BUSY)
            $display("FAIL busy cyc=%0d actual=%0h required=%0h", cyc, a, sb[i].v);
          else if (sb[i].idx == IDX_READY)
            $display("FAIL wr_ready cyc=%0d actual=%0h required=%0h", cyc, a, sb[i].v);
          else
            $display("FAIL q%0d cyc=%0d actual=%0h required=%0h", sb[i].idx, cyc, a, sb[i].v);
        end
        sb.delete(i);
      end
    end
  end

  initial begin
    reset    = 1'b1;
    wr_valid = 1'b0;
    wr_sel   = '0;
    wr_data  = '0;
    wr_be    = '0;
    clr_req  = 1'b0;

    // Reset held for two edges.
    step();
    expect_at(0, IDX_READY, 64'd0);
    expect_at(0, IDX_BUSY, 64'd0);
    step();
    for (int k = 0; k < 16; k++) expect_at(0, k, 64'd0);
    expect_at(0, IDX_BUSY, 64'd0);
    reset = 1'b0;
    #1;
    expect_at(0, IDX_READY, 64'd1);

    // Full write to q5.
    wr_valid = 1'b1; wr_sel = 4'd5; wr_data = 64'hDEAD_BEEF_0123_4567; wr_be = 8'hFF;
    expect_at(1, 5, 64'hDEAD_BEEF_0123_4567);
    expect_at(1, 4, 64'd0);
    expect_at(1, 6, 64'd0);
    step();

    // Low-half byte mask.
    wr_sel = 4'd5; wr_data = 64'hFFFF_FFFF_FFFF_FFFF; wr_be = 8'h0F;
    expect_at(1, 5, 64'hDEAD_BEEF_FFFF_FFFF);
    step();

    // Write to the hardwired-zero register.
    wr_sel = 4'd0; wr_data = 64'h1; wr_be = 8'hFF;
    expect_at(0, IDX_READY, 64'd1);
    expect_at(1, 0, 64'd0);
    expect_at(1, 5, 64'hDEAD_BEEF_FFFF_FFFF);
    step();

    // Accepted write with no byte enables changes nothing.
    wr_sel = 4'd5; wr_data = 64'h0; wr_be = 8'h00;
    expect_at(0, IDX_READY, 64'd1);
    expect_at(1, 5, 64'hDEAD_BEEF_FFFF_FFFF);
    step();

    // Fill q1..q15 with their index.
    for (int k = 1; k < 16; k++) begin
      wr_sel = 4'(k); wr_data = 64'(k); wr_be = 8'hFF;
      expect_at(1, k, 64'(k));
      step();
    end
    wr_valid = 1'b0;

    // Clear sweep, with a repeated clr_req mid-sweep and wr_valid held late in it.
    clr_req = 1'b1;
    expect_at(0, IDX_READY, 64'd1);
    for (int d = 1; d <= 16; d++) begin
      expect_at(d, IDX_BUSY, 64'd1);
      expect_at(d, IDX_READY, 64'd0);
    end
    expect_at(17, IDX_BUSY, 64'd0);
    expect_at(17, IDX_READY, 64'd1);
    for (int k = 1; k < 16; k++) begin
      expect_at(1 + k, k, 64'(k));
      expect_at(2 + k, k, 64'd0);
    end
    expect_at(2, 0, 64'd0);
    expect_at(18, 2, 64'h77);
    expect_at(18, IDX_BUSY, 64'd0);
    for (int d = 1; d <= 18; d++) begin
      step();
      if (d == 1) clr_req = 1'b0;
      if (d == 5) clr_req = 1'b1;
      if (d == 6) clr_req = 1'b0;
      if (d == 10) begin
        wr_valid = 1'b1; wr_sel = 4'd2; wr_data = 64'h77; wr_be = 8'hFF;
      end
      if (d == 18) wr_valid = 1'b0;
    end

    // Refill so the aborted sweep leaves visibly nonzero registers behind.
    for (int k = 1; k < 16; k++) begin
      wr_valid = 1'b1; wr_sel = 4'(k); wr_data = 64'(k); wr_be = 8'hFF;
      step();
    end
    wr_valid = 1'b0;

    // Collision: clr_req with a write to q3, then reset at sweep step 7.
    c0 = cyc;
    clr_req = 1'b1;
    wr_valid = 1'b1; wr_sel = 4'd3; wr_data = 64'hA5; wr_be = 8'hFF;
    for (int d = 1; d <= 4; d++) expect_at(d, 3, 64'hA5);
    expect_at(5, 3, 64'd0);
    expect_at(1, IDX_BUSY, 64'd1);
    expect_at(7, IDX_BUSY, 64'd1);
    expect_at(8, 15, 64'd15);
    expect_at(8, 7, 64'd7);
    expect_at(8, IDX_BUSY, 64'd0);
    expect_at(8, IDX_READY, 64'd0);
    for (int k = 0; k < 16; k++) expect_at(9, k, 64'd0);
    expect_at(9, IDX_BUSY, 64'd0);
    expect_at(9, IDX_READY, 64'd1);
    expect_at(10, IDX_BUSY, 64'd0);
    for (int d = 1; d <= 10; d++) begin
      step();
      if (d == 1) begin clr_req = 1'b0; wr_valid = 1'b0; end
      if (d == 8) reset = 1'b1;
      if (d == 9) reset = 1'b0;
    end

    // Drain the scoreboard within a bounded number of cycles.
    for (int w = 0; w < 50 && sb.size() > 0; w++) step();
    if (sb.size() > 0) begin
      $display("FAIL scoreboard_drain pending=%0d required=0", sb.size());
      bad += sb.size();
      total += sb.size();
    end
    if (c0 < 0) $display("unreachable");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
